noc_adaptive_route_selector: RTL and testbench
==============================================

Name: noc_adaptive_route_selector

Overview:
- Per-VC route computation stage between the input VC buffers and the output VC merge/arbiter of a mesh router.
- Computes a one-hot output-port route from each header flit, using run-time-selectable XY, YX or west-first adaptive routing.
- Freezes the route from the header's first valid cycle until tail acceptance, checks packet framing, and drives request, free, sop and eop per port per VC to the port arbiters.

Parameters:
CHANNELS, Noc_VC_Channel, number of input VCs
DATA_WIDTH, Noc_Data_Width, flit width
ID_X_WIDTH, Noc_ID_X_Width, X coordinate width
ID_Y_WIDTH, Noc_ID_Y_Width, Y coordinate width
DEST_LSB, Noc_Dest_Point, LSB of destination field; field is ID_X_WIDTH+ID_Y_WIDTH bits, X in upper bits
ACTIVATE_PORT, 5'b11111, enabled ports, bit order E,W,S,N,L

Ports:
noc_clk  in  1  clock
noc_rst_n  in  1  reset; asynchronous, active-low
id_x  in  ID_X_WIDTH  router X
id_y  in  ID_Y_WIDTH  router Y
route_mode  in  2  0=XY, 1=YX, 2=west-first adaptive, 3=reserved (treated as XY)
congested  in  5  per-port congestion hint (adaptive mode only)
in_valid  in  CHANNELS  flit valid per VC
in_ready  in  CHANNELS  flit consumed downstream per VC
in_flit  in  CHANNELS*DATA_WIDTH  flit per VC; bits [DATA_WIDTH-1:DATA_WIDTH-2] = type: 01 head, 00 body, 10 tail, 11 head+tail
route_onehot  out  5*CHANNELS  current route per VC
port_request  out  5*CHANNELS  index p*CHANNELS+i
port_free  out  5*CHANNELS  in_ready steered to the routed port
port_sop  out  5*CHANNELS  header valid on the routed port
port_eop  out  5*CHANNELS  tail handshake on the routed port
drop  out  CHANNELS  discard the current flit (protocol error)
err_clear  in  1  clears proto_err
proto_err  out  CHANNELS  sticky framing-error flag

Behaviour:
- Reset: all VC FSMs IDLE, latched routes 0, proto_err 0. All outputs 0.
- Per-VC FSM states: IDLE, HDR_PEND, BODY.
- IDLE + valid + head: route is computed combinationally and is visible the same cycle.
  - Handshake in the same cycle: go to BODY, or stay IDLE if the type is head+tail.
  - No handshake: latch the route and go to HDR_PEND.
- HDR_PEND: the latched route is used and not recomputed, even if congested changes. Handshake goes to BODY, or to IDLE for head+tail.
- BODY: the latched route is used. A tail handshake returns to IDLE.
- IDLE + valid + non-head flit:
  - drop=1 and proto_err set.
  - No request and route_onehot=0.
- BODY + valid + head flit:
  - proto_err set.
  - The flit is treated as a new header: route recomputed, no eop for the truncated packet.
- The FSM advances only on valid&&in_ready.
- Outputs for enabled port p (ACTIVATE_PORT[p]=1) with route[p]=1:
  - request = valid.
  - free = in_ready.
  - sop = valid&&head.
  - eop = valid&&in_ready&&tail.
  - All four are 0 for any other port.
- Route computation, with dx/dy the destination coordinates:
  - XY mode: E if dx>x, else W if dx<x, else S if dy>y, else N if dy<y, else L.
  - YX mode: the Y comparisons are resolved before X.
  - Adaptive mode:
    - dx<x gives W (west-first).
    - Otherwise the candidates are the productive set {E if dx>x, S if dy>y, N if dy<y}.
    - Pick the first uncongested candidate in priority E,S,N. If all candidates are congested, pick the highest-priority candidate.
    - An empty set gives L.
  - A candidate whose port is disabled is removed from the set. An empty result gives L.
  - A disabled L port still yields L and proto_err is set; requests are suppressed.
- proto_err: set has priority over err_clear in the same cycle. It takes effect one cycle after the event.
- VCs are fully independent.
- Reset mid-packet returns the FSM to IDLE. The next body flit is then flagged.

Decomposition:
- Noc_parameters package: e_route enum (one-hot), e_route_mode enum, e_flit_type enum, flit-type bit-position constants.
- Sub-module noc_route_compute: purely combinational. Inputs are destination, id, mode, congested and ACTIVATE_PORT; the output is the one-hot route. One instance per VC.

Test Plan:
- XY mode, id=(2,2), dest=(4,1), 3-flit packet, ready held high:
  - E request on each of the 3 cycles.
  - sop on cycle 0, eop on cycle 2.
  - FSM back to IDLE.
- Adaptive mode, id=(1,1), dest=(3,3), congested=00001: route S. With congested=00101: route E (all congested, so priority E).
- Header held in HDR_PEND 3 cycles, congested toggled each cycle: route stays constant until the handshake.
- Body flit in IDLE: drop=1, no request, proto_err=1 the next cycle. Then err_clear pulse: proto_err=0.
- ACTIVATE_PORT=5'b11110 (E disabled), XY mode, dest east: route L.
- Two VCs, head+tail on VC0 to W while a 2-flit packet is on VC1 to N:
  - VC0 gives sop and eop on W in the same cycle.
  - VC1 gives sop then eop on N.
  - No cross-VC interference.

Source files
------------

// File: rtl/noc_adaptive_route_selector_pkg.sv
// Shared types and constants for the adaptive route selector: one-hot port
// encodings, routing modes, flit type codes and the candidate priority picker.
package noc_adaptive_route_selector_pkg;

  localparam int NUM_PORTS = 5;
  localparam int PORT_E    = 0;
  localparam int PORT_W    = 1;
  localparam int PORT_S    = 2;
  localparam int PORT_N    = 3;
  localparam int PORT_L    = 4;

  // Bit offsets inside the 2-bit flit type field (which sits at the flit MSBs).
  localparam int TYPE_HEAD_BIT = 0;
  localparam int TYPE_TAIL_BIT = 1;

  typedef enum logic [4:0] {
    ROUTE_E = 5'b00001,
    ROUTE_W = 5'b00010,
    ROUTE_S = 5'b00100,
    ROUTE_N = 5'b01000,
    ROUTE_L = 5'b10000
  } e_route;

  typedef enum logic [1:0] {
    MODE_XY   = 2'd0,
    MODE_YX   = 2'd1,
    MODE_WF   = 2'd2,
    MODE_RSVD = 2'd3
  } e_route_mode;

  typedef enum logic [1:0] {
    FLIT_BODY     = 2'b00,
    FLIT_HEAD     = 2'b01,
    FLIT_TAIL     = 2'b10,
    FLIT_HEADTAIL = 2'b11
  } e_flit_type;

  // Priority E, S, N, W; an empty candidate set falls back to local delivery.
  function automatic logic [4:0] pick_route(input logic [4:0] cand);
    if (cand[PORT_E])      return ROUTE_E;
    else if (cand[PORT_S]) return ROUTE_S;
    else if (cand[PORT_N]) return ROUTE_N;
    else if (cand[PORT_W]) return ROUTE_W;
    else                   return ROUTE_L;
  endfunction

endpackage

// File: rtl/noc_route_compute.sv
// Purely combinational one-hot route computation for a single header flit,
// supporting XY, YX and west-first adaptive routing with disabled-port pruning.
module noc_route_compute
  import noc_adaptive_route_selector_pkg::*;
#(
  parameter int         ID_X_WIDTH    = 3,
  parameter int         ID_Y_WIDTH    = 3,
  parameter logic [4:0] ACTIVATE_PORT = 5'b11111
) (
  input  logic [ID_X_WIDTH-1:0] dest_x,
  input  logic [ID_Y_WIDTH-1:0] dest_y,
  input  logic [ID_X_WIDTH-1:0] id_x,
  input  logic [ID_Y_WIDTH-1:0] id_y,
  input  logic [1:0]            route_mode,
  input  logic [4:0]            congested,
  output logic [4:0]            route
);

  logic go_e, go_w, go_s, go_n;
  logic [4:0] cand, allowed, relaxed;

  // Deterministic modes yield a single candidate, so the congestion filter
  // below can never change their choice; only west-first sees a real set.
  always_comb begin
    go_e = dest_x > id_x;
    go_w = dest_x < id_x;
    go_s = dest_y > id_y;
    go_n = dest_y < id_y;
    cand = '0;
    case (e_route_mode'(route_mode))
      MODE_YX: begin
        if (go_s)      cand = ROUTE_S;
        else if (go_n) cand = ROUTE_N;
        else if (go_e) cand = ROUTE_E;
        else if (go_w) cand = ROUTE_W;
      end
      MODE_WF: begin
        if (go_w) cand = ROUTE_W;
        else begin
          cand[PORT_E] = go_e;
          cand[PORT_S] = go_s;
          cand[PORT_N] = go_n;
        end
      end
      default: begin
        if (go_e)      cand = ROUTE_E;
        else if (go_w) cand = ROUTE_W;
        else if (go_s) cand = ROUTE_S;
        else if (go_n) cand = ROUTE_N;
      end
    endcase
    allowed = cand & ACTIVATE_PORT;
    relaxed = allowed & ~congested;
    if (relaxed != '0) route = pick_route(relaxed);
    else               route = pick_route(allowed);
  end

endmodule

// File: rtl/noc_adaptive_route_selector.sv
// Per-VC route computation stage: freezes each packet's route from header to
// tail, checks framing, and steers request/free/sop/eop to the port arbiters.
module noc_adaptive_route_selector
  import noc_adaptive_route_selector_pkg::*;
#(
  parameter int         CHANNELS      = 2,
  parameter int         DATA_WIDTH    = 32,
  parameter int         ID_X_WIDTH    = 3,
  parameter int         ID_Y_WIDTH    = 3,
  parameter int         DEST_LSB      = 0,
  parameter logic [4:0] ACTIVATE_PORT = 5'b11111
) (
  input  logic                           noc_clk,
  input  logic                           noc_rst_n,
  input  logic [ID_X_WIDTH-1:0]          id_x,
  input  logic [ID_Y_WIDTH-1:0]          id_y,
  input  logic [1:0]                     route_mode,
  input  logic [4:0]                     congested,
  input  logic [CHANNELS-1:0]            in_valid,
  input  logic [CHANNELS-1:0]            in_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0] in_flit,
  output logic [5*CHANNELS-1:0]          route_onehot,
  output logic [5*CHANNELS-1:0]          port_request,
  output logic [5*CHANNELS-1:0]          port_free,
  output logic [5*CHANNELS-1:0]          port_sop,
  output logic [5*CHANNELS-1:0]          port_eop,
  output logic [CHANNELS-1:0]            drop,
  input  logic                           err_clear,
  output logic [CHANNELS-1:0]            proto_err
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_HDR_PEND = 2'd1;
  localparam logic [1:0] ST_BODY     = 2'd2;
  localparam int         DEST_W      = ID_X_WIDTH + ID_Y_WIDTH;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_vc
    logic [DATA_WIDTH-1:0] flit;
    logic [DEST_W-1:0]     dest;
    e_flit_type            ftype;
    logic                  valid, ready, hs, is_head, is_tail;
    logic [1:0]            state, next_state;
    logic [4:0]            route_q, route_calc, route_cur, en_route;
    logic                  latch, drop_c, err_set, err_q;
    logic                  unused_flit;

    assign flit        = in_flit[g*DATA_WIDTH +: DATA_WIDTH];
    assign dest        = flit[DEST_LSB +: DEST_W];
    assign ftype       = e_flit_type'(flit[DATA_WIDTH-1 -: 2]);
    assign is_head     = ftype[TYPE_HEAD_BIT];
    assign is_tail     = ftype[TYPE_TAIL_BIT];
    assign valid       = in_valid[g];
    assign ready       = in_ready[g];
    assign hs          = valid & ready;
    assign unused_flit = ^flit;

    noc_route_compute #(
      .ID_X_WIDTH   (ID_X_WIDTH),
      .ID_Y_WIDTH   (ID_Y_WIDTH),
      .ACTIVATE_PORT(ACTIVATE_PORT)
    ) u_route (
      .dest_x    (dest[DEST_W-1 -: ID_X_WIDTH]),
      .dest_y    (dest[ID_Y_WIDTH-1:0]),
      .id_x      (id_x),
      .id_y      (id_y),
      .route_mode(route_mode),
      .congested (congested),
      .route     (route_calc)
    );

    // A header seen in IDLE or BODY uses the live route and latches it; in
    // HDR_PEND the latched copy is held so congestion changes cannot move it.
    always_comb begin
      next_state = state;
      route_cur  = '0;
      latch      = 1'b0;
      drop_c     = 1'b0;
      err_set    = 1'b0;
      case (state)
        ST_HDR_PEND: begin
          route_cur = route_q;
          if (hs) next_state = is_tail ? ST_IDLE : ST_BODY;
        end
        ST_BODY: begin
          if (valid && is_head) begin
            route_cur  = route_calc;
            latch      = 1'b1;
            err_set    = 1'b1;
            next_state = hs ? (is_tail ? ST_IDLE : ST_BODY) : ST_HDR_PEND;
          end else begin
            route_cur = route_q;
            if (hs && is_tail) next_state = ST_IDLE;
          end
        end
        default: begin
          next_state = ST_IDLE;
          if (valid && is_head) begin
            route_cur  = route_calc;
            latch      = 1'b1;
            next_state = hs ? (is_tail ? ST_IDLE : ST_BODY) : ST_HDR_PEND;
          end else if (valid) begin
            drop_c  = 1'b1;
            err_set = 1'b1;
          end
        end
      endcase
      if (valid && is_head && route_cur == ROUTE_L && !ACTIVATE_PORT[PORT_L])
        err_set = 1'b1;
    end

    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
      if (!noc_rst_n) begin
        state   <= ST_IDLE;
        route_q <= '0;
        err_q   <= 1'b0;
      end else begin
        state <= next_state;
        if (latch) route_q <= route_calc;
        if (err_set)        err_q <= 1'b1;
        else if (err_clear) err_q <= 1'b0;
      end
    end

    assign en_route              = route_cur & ACTIVATE_PORT;
    assign route_onehot[g*5 +: 5] = route_cur;
    assign drop[g]               = drop_c;
    assign proto_err[g]          = err_q;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      assign port_request[p*CHANNELS+g] = valid & en_route[p];
      assign port_free[p*CHANNELS+g]    = ready & en_route[p];
      assign port_sop[p*CHANNELS+g]     = valid & is_head & en_route[p];
      assign port_eop[p*CHANNELS+g]     = hs & is_tail & en_route[p];
    end
  end

endmodule

// File: tb/tb_noc_adaptive_route_selector.sv
// Table-driven bench for the adaptive route selector with an expected-result
// queue; a second instance has the east port disabled.
module tb_noc_adaptive_route_selector;

  localparam int CH = 2;
  localparam int DW = 16;
  localparam int XW = 3;
  localparam int YW = 3;

  localparam logic [4:0] RE = 5'b00001;
  localparam logic [4:0] RW = 5'b00010;
  localparam logic [4:0] RS = 5'b00100;
  localparam logic [4:0] RN = 5'b01000;
  localparam logic [4:0] RL = 5'b10000;
  localparam int PE = 0, PW = 1, PS = 2, PN = 3, PL = 4;

  localparam logic [1:0] FT_BODY = 2'b00;
  localparam logic [1:0] FT_HEAD = 2'b01;
  localparam logic [1:0] FT_TAIL = 2'b10;
  localparam logic [1:0] FT_HT   = 2'b11;

  logic            noc_clk = 1'b0;
  logic            noc_rst_n = 1'b0;
  logic [XW-1:0]   id_x = '0;
  logic [YW-1:0]   id_y = '0;
  logic [1:0]      route_mode = '0;
  logic [4:0]      congested = '0;
  logic [CH-1:0]   in_valid = '0;
  logic [CH-1:0]   in_ready = '0;
  logic [CH*DW-1:0] in_flit = '0;
  logic            err_clear = 1'b0;

  logic [5*CH-1:0] route_onehot, port_request, port_free, port_sop, port_eop;
  logic [CH-1:0]   drop, proto_err;
  logic [5*CH-1:0] ne_route, ne_req, ne_unused_free, ne_unused_sop, ne_unused_eop;
  logic [CH-1:0]   ne_unused_drop, ne_unused_err;

  int errors = 0;
  int checks = 0;
  int vec_num = 0;

  always #5 noc_clk = ~noc_clk;

  noc_adaptive_route_selector #(
    .CHANNELS(CH), .DATA_WIDTH(DW), .ID_X_WIDTH(XW), .ID_Y_WIDTH(YW),
    .DEST_LSB(0), .ACTIVATE_PORT(5'b11111)
  ) dut (
    .noc_clk(noc_clk), .noc_rst_n(noc_rst_n), .id_x(id_x), .id_y(id_y),
    .route_mode(route_mode), .congested(congested), .in_valid(in_valid),
    .in_ready(in_ready), .in_flit(in_flit), .route_onehot(route_onehot),
    .port_request(port_request), .port_free(port_free), .port_sop(port_sop),
    .port_eop(port_eop), .drop(drop), .err_clear(err_clear), .proto_err(proto_err)
  );

  noc_adaptive_route_selector #(
    .CHANNELS(CH), .DATA_WIDTH(DW), .ID_X_WIDTH(XW), .ID_Y_WIDTH(YW),
    .DEST_LSB(0), .ACTIVATE_PORT(5'b11110)
  ) dut_ne (
    .noc_clk(noc_clk), .noc_rst_n(noc_rst_n), .id_x(id_x), .id_y(id_y),
    .route_mode(route_mode), .congested(congested), .in_valid(in_valid),
    .in_ready(in_ready), .in_flit(in_flit), .route_onehot(ne_route),
    .port_request(ne_req), .port_free(ne_unused_free), .port_sop(ne_unused_sop),
    .port_eop(ne_unused_eop), .drop(ne_unused_drop), .err_clear(err_clear),
    .proto_err(ne_unused_err)
  );

  typedef struct {
    int          id;
    logic        rst;
    logic [1:0]  mode;
    logic [2:0]  idx, idy;
    logic [4:0]  cong;
    logic        clr;
    logic [1:0]  vld, rdy;
    logic [15:0] f0, f1;
    logic [9:0]  e_route, e_req, e_free, e_sop, e_eop;
    logic [1:0]  e_drop, e_err;
    logic        chk_ne;
    logic [9:0]  e_route_ne, e_req_ne;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[34];

  function automatic logic [15:0] fl(input logic [1:0] t, input int dx, input int dy);
    return {t, 8'h00, 3'(dx), 3'(dy)};
  endfunction

  function automatic logic [9:0] rt(input int vc, input logic [4:0] r);
    return 10'(r) << (vc * 5);
  endfunction

  function automatic logic [9:0] pb(input int p, input int vc);
    return 10'(1) << (p * CH + vc);
  endfunction

  function automatic vec_t mk(input int rst, input int mode, input int idx, input int idy,
                              input int cong, input int clr, input int vld, input int rdy,
                              input logic [15:0] f0, input logic [15:0] f1,
                              input logic [9:0] er, input logic [9:0] eq, input logic [9:0] ef,
                              input logic [9:0] es, input logic [9:0] ee,
                              input int ed, input int eerr);
    vec_t v;
    v.id = 0; v.rst = 1'(rst); v.mode = 2'(mode); v.idx = 3'(idx); v.idy = 3'(idy);
    v.cong = 5'(cong); v.clr = 1'(clr); v.vld = 2'(vld); v.rdy = 2'(rdy);
    v.f0 = f0; v.f1 = f1; v.e_route = er; v.e_req = eq; v.e_free = ef;
    v.e_sop = es; v.e_eop = ee; v.e_drop = 2'(ed); v.e_err = 2'(eerr);
    v.chk_ne = 1'b0; v.e_route_ne = '0; v.e_req_ne = '0;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    noc_rst_n  = ~v.rst;
    route_mode = v.mode;
    id_x       = v.idx;
    id_y       = v.idy;
    congested  = v.cong;
    err_clear  = v.clr;
    in_valid   = v.vld;
    in_ready   = v.rdy;
    in_flit    = {v.f1, v.f0};
    v.id       = vec_num;
    vec_num++;
    exp_q.push_back(v);
  endtask

  task automatic cmp(input string what, input int id, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s vec%0d: got %b expected %b", what, id, act, exp);
    end
  endtask

  task automatic checkOutput();
    vec_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries expected 1");
      return;
    end
    e = exp_q.pop_front();
    cmp("route",   e.id, route_onehot, e.e_route);
    cmp("request", e.id, port_request, e.e_req);
    cmp("free",    e.id, port_free,    e.e_free);
    cmp("sop",     e.id, port_sop,     e.e_sop);
    cmp("eop",     e.id, port_eop,     e.e_eop);
    cmp("drop",    e.id, 10'(drop),      10'(e.e_drop));
    cmp("perr",    e.id, 10'(proto_err), 10'(e.e_err));
    if (e.chk_ne) begin
      cmp("ne_route",   e.id, ne_route, e.e_route_ne);
      cmp("ne_request", e.id, ne_req,   e.e_req_ne);
    end
  endtask

  task automatic step(input vec_t v);
    @(negedge noc_clk);
    applyStimulus(v);
    #1 checkOutput();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // reset, then XY 3-flit packet to the east
    tbl[0]  = mk(1,0,2,2,0,0,'b00,'b00,'0,'0, '0,'0,'0,'0,'0, 0,0);
    tbl[1]  = mk(0,0,2,2,0,0,'b01,'b01,fl(FT_HEAD,4,1),'0, rt(0,RE),pb(PE,0),pb(PE,0),pb(PE,0),'0, 0,0);
    tbl[2]  = mk(0,0,2,2,0,0,'b01,'b01,fl(FT_BODY,4,1),'0, rt(0,RE),pb(PE,0),pb(PE,0),'0,'0, 0,0);
    tbl[3]  = mk(0,0,2,2,0,0,'b01,'b01,fl(FT_TAIL,4,1),'0, rt(0,RE),pb(PE,0),pb(PE,0),'0,pb(PE,0), 0,0);
    tbl[4]  = mk(0,0,2,2,0,0,'b00,'b01,'0,'0, '0,'0,'0,'0,'0, 0,0);
    // west-first with congestion
    tbl[5]  = mk(0,2,1,1,'b00001,0,'b01,'b01,fl(FT_HT,3,3),'0, rt(0,RS),pb(PS,0),pb(PS,0),pb(PS,0),pb(PS,0), 0,0);
    tbl[6]  = mk(0,2,1,1,'b00101,0,'b01,'b01,fl(FT_HT,3,3),'0, rt(0,RE),pb(PE,0),pb(PE,0),pb(PE,0),pb(PE,0), 0,0);
    // header stalled while congestion toggles
    tbl[7]  = mk(0,2,1,1,'b00000,0,'b01,'b00,fl(FT_HEAD,3,3),'0, rt(0,RE),pb(PE,0),'0,pb(PE,0),'0, 0,0);
    tbl[8]  = mk(0,2,1,1,'b00001,0,'b01,'b00,fl(FT_HEAD,3,3),'0, rt(0,RE),pb(PE,0),'0,pb(PE,0),'0, 0,0);
    tbl[9]  = mk(0,2,1,1,'b00000,0,'b01,'b00,fl(FT_HEAD,3,3),'0, rt(0,RE),pb(PE,0),'0,pb(PE,0),'0, 0,0);
    tbl[10] = mk(0,2,1,1,'b00001,0,'b01,'b01,fl(FT_HEAD,3,3),'0, rt(0,RE),pb(PE,0),pb(PE,0),pb(PE,0),'0, 0,0);
    tbl[11] = mk(0,2,1,1,'b00001,0,'b01,'b01,fl(FT_TAIL,3,3),'0, rt(0,RE),pb(PE,0),pb(PE,0),'0,pb(PE,0), 0,0);
    // body flit while idle, then clear
    tbl[12] = mk(0,0,2,2,0,0,'b01,'b01,fl(FT_BODY,4,1),'0, '0,'0,'0,'0,'0, 'b01,0);
    tbl[13] = mk(0,0,2,2,0,0,'b00,'b00,'0,'0, '0,'0,'0,'0,'0, 0,'b01);
    tbl[14] = mk(0,0,2,2,0,1,'b00,'b00,'0,'0, '0,'0,'0,'0,'0, 0,'b01);
    tbl[15] = mk(0,0,2,2,0,0,'b00,'b00,'0,'0, '0,'0,'0,'0,'0, 0,0);
    // east destination; the second instance has east disabled
    tbl[16] = mk(0,0,2,2,0,0,'b01,'b01,fl(FT_HT,4,2),'0, rt(0,RE),pb(PE,0),pb(PE,0),pb(PE,0),pb(PE,0), 0,0);
    tbl[16].chk_ne = 1'b1;
    tbl[16].e_route_ne = rt(0,RL);
    tbl[16].e_req_ne   = pb(PL,0);
    // two independent VCs
    tbl[17] = mk(0,0,2,2,0,0,'b11,'b11,fl(FT_HT,0,2),fl(FT_HEAD,2,0),
                 rt(0,RW)|rt(1,RN), pb(PW,0)|pb(PN,1), pb(PW,0)|pb(PN,1), pb(PW,0)|pb(PN,1), pb(PW,0), 0,0);
    tbl[18] = mk(0,0,2,2,0,0,'b10,'b11,'0,fl(FT_TAIL,2,0), rt(1,RN),pb(PN,1),pb(PN,1),'0,pb(PN,1), 0,0);
    tbl[19] = mk(0,0,2,2,0,0,'b00,'b00,'0,'0, '0,'0,'0,'0,'0, 0,0);
    // header arriving mid-packet truncates the old one
    tbl[20] = mk(0,0,2,2,0,0,'b01,'b01,fl(FT_HEAD,4,2),'0, rt(0,RE),pb(PE,0),pb(PE,0),pb(PE,0),'0, 0,0);
    tbl[21] = mk(0,0,2,2,0,0,'b01,'b01,fl(FT_HEAD,0,2),'0, rt(0,RW),pb(PW,0),pb(PW,0),pb(PW,0),'0, 0,0);
    tbl[22] = mk(0,0,2,2,0,0,'b01,'b01,fl(FT_TAIL,0,2),'0, rt(0,RW),pb(PW,0),pb(PW,0),'0,pb(PW,0), 0,'b01);
    tbl[23] = mk(0,0,2,2,0,1,'b00,'b00,'0,'0, '0,'0,'0,'0,'0, 0,'b01);
    tbl[24] = mk(0,0,2,2,0,0,'b00,'b00,'0,'0, '0,'0,'0,'0,'0, 0,0);
    // YX, reserved mode and west-first westward
    tbl[25] = mk(0,1,2,2,0,0,'b01,'b01,fl(FT_HT,4,4),'0, rt(0,RS),pb(PS,0),pb(PS,0),pb(PS,0),pb(PS,0), 0,0);
    tbl[26] = mk(0,3,2,2,0,0,'b01,'b01,fl(FT_HT,4,4),'0, rt(0,RE),pb(PE,0),pb(PE,0),pb(PE,0),pb(PE,0), 0,0);
    tbl[27] = mk(0,2,2,2,0,0,'b01,'b01,fl(FT_HT,0,4),'0, rt(0,RW),pb(PW,0),pb(PW,0),pb(PW,0),pb(PW,0), 0,0);
    // reset in the middle of a packet
    tbl[28] = mk(0,0,2,2,0,0,'b01,'b01,fl(FT_HEAD,4,2),'0, rt(0,RE),pb(PE,0),pb(PE,0),pb(PE,0),'0, 0,0);
    tbl[29] = mk(1,0,2,2,0,0,'b00,'b00,'0,'0, '0,'0,'0,'0,'0, 0,0);
    tbl[30] = mk(0,0,2,2,0,0,'b01,'b01,fl(FT_BODY,4,2),'0, '0,'0,'0,'0,'0, 'b01,0);
    tbl[31] = mk(0,0,2,2,0,0,'b00,'b00,'0,'0, '0,'0,'0,'0,'0, 0,'b01);
    tbl[32] = mk(0,0,2,2,0,1,'b00,'b00,'0,'0, '0,'0,'0,'0,'0, 0,'b01);
    tbl[33] = mk(0,0,2,2,0,0,'b00,'b00,'0,'0, '0,'0,'0,'0,'0, 0,0);

    repeat (2) @(posedge noc_clk);
    for (int i = 0; i < 34; i++) step(tbl[i]);

    // head+tail stalled in HDR_PEND while its destination field changes,
    // then accepted; a following body flit proves the VC went back to IDLE
    step(mk(0,0,2,2,0,0,'b01,'b00,fl(FT_HT,2,4),'0, rt(0,RS),pb(PS,0),'0,pb(PS,0),'0, 0,0));
    step(mk(0,0,2,2,0,0,'b01,'b00,fl(FT_HT,4,2),'0, rt(0,RS),pb(PS,0),'0,pb(PS,0),'0, 0,0));
    step(mk(0,0,2,2,0,0,'b01,'b01,fl(FT_HT,4,2),'0, rt(0,RS),pb(PS,0),pb(PS,0),pb(PS,0),pb(PS,0), 0,0));
    step(mk(0,0,2,2,0,0,'b01,'b01,fl(FT_BODY,4,2),'0, '0,'0,'0,'0,'0, 'b01,0));
    step(mk(0,0,2,2,0,0,'b00,'b00,'0,'0, '0,'0,'0,'0,'0, 0,'b01));
    step(mk(0,0,2,2,0,1,'b00,'b00,'0,'0, '0,'0,'0,'0,'0, 0,'b01));
    step(mk(0,0,2,2,0,0,'b00,'b00,'0,'0, '0,'0,'0,'0,'0, 0,0));

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end

    @(negedge noc_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
